// File: rtl/e203_axi_pkg.sv
// e203_axi_pkg: shared AXI encodings, FSM state types and beat helpers for the expl_axi responder.
`ifndef E203_ADDR_SIZE
`define E203_ADDR_SIZE 32
`endif
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
package e203_axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'b010;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? addr : addr + 32'd4;
    endfunction
    // Range test runs at 33 bits so a window ending at 4 GiB cannot wrap.
    function automatic logic beat_err(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned aw, input logic [2:0] size,
                                      input logic [1:0] burst);
        logic [32:0] lim;
        lim = {1'b0, base} + (33'd4 << aw);
        return ({1'b0, addr} < {1'b0, base}) || ({1'b0, addr} >= lim) ||
               (size != SIZE_WORD) || (burst >= BURST_WRAP);
    endfunction
endpackage

// File: rtl/e203_expl_axi_mem.sv
// e203_expl_axi_mem: flop-array word storage, one byte-strobed write port, one async read port.
// Ports: clk; we_i/waddr_i/wdata_i/wstrb_i write port; raddr_i/rdata_o read port.
module e203_expl_axi_mem #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DW-1:0]   rdata_o
);
    logic [DW-1:0] mem_q [2**AW];
    always_ff @(posedge clk)
        if (we_i)
            for (int i = 0; i < DW/8; i++)
                if (wstrb_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/e203_expl_axi_slv.sv
// e203_expl_axi_slv: AXI3-style memory responder for the SoC expl_axi port, independent read/write FSMs.
// Ports: clk, rst_n (sync, active-low); AR/AW request channels; R/W data channels; B response channel.
module e203_expl_axi_slv
    import e203_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          MEM_AW    = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        expl_axi_arvalid,
    output logic                        expl_axi_arready,
    input  logic [`E203_ADDR_SIZE-1:0]  expl_axi_araddr,
    input  logic [3:0]                  expl_axi_arcache,
    input  logic [2:0]                  expl_axi_arprot,
    input  logic [1:0]                  expl_axi_arlock,
    input  logic [1:0]                  expl_axi_arburst,
    input  logic [3:0]                  expl_axi_arlen,
    input  logic [2:0]                  expl_axi_arsize,
    input  logic                        expl_axi_awvalid,
    output logic                        expl_axi_awready,
    input  logic [`E203_ADDR_SIZE-1:0]  expl_axi_awaddr,
    input  logic [3:0]                  expl_axi_awcache,
    input  logic [2:0]                  expl_axi_awprot,
    input  logic [1:0]                  expl_axi_awlock,
    input  logic [1:0]                  expl_axi_awburst,
    input  logic [3:0]                  expl_axi_awlen,
    input  logic [2:0]                  expl_axi_awsize,
    output logic                        expl_axi_rvalid,
    input  logic                        expl_axi_rready,
    output logic [`E203_XLEN-1:0]       expl_axi_rdata,
    output logic [1:0]                  expl_axi_rresp,
    output logic                        expl_axi_rlast,
    input  logic                        expl_axi_wvalid,
    output logic                        expl_axi_wready,
    input  logic [`E203_XLEN-1:0]       expl_axi_wdata,
    input  logic [`E203_XLEN/8-1:0]     expl_axi_wstrb,
    input  logic                        expl_axi_wlast,
    output logic                        expl_axi_bvalid,
    input  logic                        expl_axi_bready,
    output logic [1:0]                  expl_axi_bresp
);
    logic unused_ok;
    assign unused_ok = ^{expl_axi_arcache, expl_axi_arprot, expl_axi_arlock,
                         expl_axi_awcache, expl_axi_awprot, expl_axi_awlock};

    w_state_e    w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [3:0]  w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic [2:0]  w_size_q, w_size_d;
    logic        w_err_q, w_err_d, w_last_beat, w_beat_err, mem_we;

    r_state_e    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d, r_lk_addr, rdata_q, rdata_d, mem_rdata;
    logic [3:0]  r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic [1:0]  r_burst_q, r_burst_d, rresp_q, rresp_d;
    logic [2:0]  r_size_q, r_size_d;
    logic        r_lk_err, r_idle;

    e203_expl_axi_mem #(.AW(MEM_AW), .DW(`E203_XLEN)) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (w_addr_q[MEM_AW+1:2]),
        .wdata_i (expl_axi_wdata),
        .wstrb_i (expl_axi_wstrb),
        .raddr_i (r_lk_addr[MEM_AW+1:2]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_burst_d = w_burst_q;
        w_size_d  = w_size_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        expl_axi_awready = 1'b0;
        expl_axi_wready  = 1'b0;
        expl_axi_bvalid  = 1'b0;
        w_last_beat = (w_beat_q == w_len_q);
        w_beat_err  = beat_err(w_addr_q, BASE_ADDR, MEM_AW, w_size_q, w_burst_q) ||
                      (expl_axi_wlast != w_last_beat);
        case (w_state_q)
            W_IDLE: begin
                expl_axi_awready = 1'b1;
                if (expl_axi_awvalid) begin
                    w_addr_d  = expl_axi_awaddr;
                    w_len_d   = expl_axi_awlen;
                    w_burst_d = expl_axi_awburst;
                    w_size_d  = expl_axi_awsize;
                    w_beat_d  = 4'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                expl_axi_wready = 1'b1;
                if (expl_axi_wvalid) begin
                    mem_we   = !w_beat_err;
                    w_err_d  = w_err_q | w_beat_err;
                    w_addr_d = next_addr(w_addr_q, w_burst_q);
                    // Hold the counter on the final beat so len=15 never wraps.
                    if (w_last_beat) w_state_d = W_RESP;
                    else w_beat_d = w_beat_q + 4'd1;
                end
            end
            W_RESP: begin
                expl_axi_bvalid = 1'b1;
                if (expl_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign expl_axi_bresp = (expl_axi_bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // One lookup serves both the AR capture and the next beat of an open burst;
    // the async read sees storage before any same-edge write lands.
    assign r_idle    = (r_state_q == R_IDLE);
    assign r_lk_addr = r_idle ? expl_axi_araddr : next_addr(r_addr_q, r_burst_q);
    assign r_lk_err  = r_idle ? beat_err(r_lk_addr, BASE_ADDR, MEM_AW, expl_axi_arsize, expl_axi_arburst)
                              : beat_err(r_lk_addr, BASE_ADDR, MEM_AW, r_size_q, r_burst_q);

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_burst_d = r_burst_q;
        r_size_d  = r_size_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        expl_axi_arready = r_idle;
        expl_axi_rvalid  = !r_idle;
        expl_axi_rlast   = !r_idle && (r_beat_q == r_len_q);
        if (r_idle && expl_axi_arvalid) begin
            r_addr_d  = expl_axi_araddr;
            r_len_d   = expl_axi_arlen;
            r_burst_d = expl_axi_arburst;
            r_size_d  = expl_axi_arsize;
            r_beat_d  = 4'd0;
            rdata_d   = r_lk_err ? 32'd0 : mem_rdata;
            rresp_d   = r_lk_err ? RESP_SLVERR : RESP_OKAY;
            r_state_d = R_DATA;
        end else if (!r_idle && expl_axi_rready) begin
            if (expl_axi_rlast) r_state_d = R_IDLE;
            else begin
                r_beat_d = r_beat_q + 4'd1;
                r_addr_d = r_lk_addr;
                rdata_d  = r_lk_err ? 32'd0 : mem_rdata;
                rresp_d  = r_lk_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign expl_axi_rdata = rdata_q;
    assign expl_axi_rresp = rresp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_burst_q <= '0;
            w_size_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_burst_q <= w_burst_d;
            w_size_q  <= w_size_d;
            w_err_q   <= w_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_burst_q <= '0;
            r_size_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_burst_q <= r_burst_d;
            r_size_q  <= r_size_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule

// File: tb/tb_e203_expl_axi_slv.sv
// tb_e203_expl_axi_slv: directed self-checking bench for the expl_axi responder.
module tb_e203_expl_axi_slv;
    import e203_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arvalid, arready, awvalid, awready;
    logic [31:0] araddr, awaddr;
    logic [1:0]  arburst, awburst;
    logic [3:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic        rvalid, rready, rlast, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    always #5 clk = ~clk;

    e203_expl_axi_slv dut (
        .clk(clk), .rst_n(rst_n),
        .expl_axi_arvalid(arvalid), .expl_axi_arready(arready), .expl_axi_araddr(araddr),
        .expl_axi_arcache(4'd0), .expl_axi_arprot(3'd0), .expl_axi_arlock(2'd0),
        .expl_axi_arburst(arburst), .expl_axi_arlen(arlen), .expl_axi_arsize(arsize),
        .expl_axi_awvalid(awvalid), .expl_axi_awready(awready), .expl_axi_awaddr(awaddr),
        .expl_axi_awcache(4'd0), .expl_axi_awprot(3'd0), .expl_axi_awlock(2'd0),
        .expl_axi_awburst(awburst), .expl_axi_awlen(awlen), .expl_axi_awsize(awsize),
        .expl_axi_rvalid(rvalid), .expl_axi_rready(rready), .expl_axi_rdata(rdata),
        .expl_axi_rresp(rresp), .expl_axi_rlast(rlast),
        .expl_axi_wvalid(wvalid), .expl_axi_wready(wready), .expl_axi_wdata(wdata),
        .expl_axi_wstrb(wstrb), .expl_axi_wlast(wlast),
        .expl_axi_bvalid(bvalid), .expl_axi_bready(bready), .expl_axi_bresp(bresp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input logic [2:0] s);
        int n;
        n = 0;
        awaddr = a; awlen = l; awburst = b; awsize = s; awvalid = 1'b1;
        while (!awready && n < 20) begin tick(); n++; end
        if (n >= 20) begin chk_cnt++; $display("FAIL aw_timeout: awready=%b required 1", awready); end
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input logic [2:0] s);
        int n;
        n = 0;
        araddr = a; arlen = l; arburst = b; arsize = s; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        if (n >= 20) begin chk_cnt++; $display("FAIL ar_timeout: arready=%b required 1", arready); end
        tick();
        arvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n;
        n = 0;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        while (!wready && n < 20) begin tick(); n++; end
        if (n >= 20) begin chk_cnt++; $display("FAIL w_timeout: wready=%b required 1", wready); end
        tick();
        wvalid = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp);
        int n;
        n = 0;
        bready = 1'b1;
        while (!bvalid && n < 20) begin tick(); n++; end
        if (n >= 20) begin chk_cnt++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid); end
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic get_r(output logic [31:0] d, output logic [1:0] r, output logic l);
        int n;
        n = 0;
        rready = 1'b1;
        while (!rvalid && n < 20) begin tick(); n++; end
        if (n >= 20) begin chk_cnt++; $display("FAIL r_timeout: rvalid=%b required 1", rvalid); end
        d = rdata; r = rresp; l = rlast;
        tick();
        rready = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [3:0] l, input logic [31:0] d0,
                               input logic [31:0] step, output logic [1:0] resp);
        do_aw(a, l, BURST_INCR, SIZE_WORD);
        for (int i = 0; i <= int'(l); i++) do_w(d0 + 32'(i) * step, 4'hF, i == int'(l));
        get_b(resp);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_cnt++; if (arready !== 1'b1) $display("FAIL rst_arready: got %b required 1", arready); else pass_cnt++;
        chk_cnt++; if (awready !== 1'b1) $display("FAIL rst_awready: got %b required 1", awready); else pass_cnt++;
        chk_cnt++; if (rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b required 0", rvalid); else pass_cnt++;
        chk_cnt++; if (wready !== 1'b0) $display("FAIL rst_wready: got %b required 0", wready); else pass_cnt++;
        chk_cnt++; if (bvalid !== 1'b0) $display("FAIL rst_bvalid: got %b required 0", bvalid); else pass_cnt++;
        chk_cnt++; if ({rdata, rresp, rlast, bresp} !== 37'd0)
            $display("FAIL rst_outs: got %h required 0", {rdata, rresp, rlast, bresp}); else pass_cnt++;
    endtask

    task automatic test_incr();
        logic [1:0] r;
        write_burst(32'h4000_0000, 4'd3, 32'h11, 32'h11, r);
        chk_cnt++; if (r !== RESP_OKAY) $display("FAIL incr_bresp: got %b required 00", r); else pass_cnt++;
        do_ar(32'h4000_0000, 4'd3, BURST_INCR, SIZE_WORD);
        chk_cnt++; if (rvalid !== 1'b1) $display("FAIL incr_latency: rvalid=%b required 1", rvalid); else pass_cnt++;
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if ({rvalid, rdata, rresp, rlast} !== {1'b1, 32'h11 * 32'(i + 1), RESP_OKAY, i == 3})
                $display("FAIL incr_beat%0d: got v=%b d=%h r=%b l=%b required d=%h l=%b",
                         i, rvalid, rdata, rresp, rlast, 32'h11 * 32'(i + 1), i == 3);
            else pass_cnt++;
            tick();
        end
        rready = 1'b0;
        chk_cnt++; if ({rvalid, arready} !== 2'b01) $display("FAIL incr_done: rvalid/arready=%b required 01", {rvalid, arready}); else pass_cnt++;
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; logic l;
        write_burst(32'h4000_0010, 4'd0, 32'd0, 32'd0, r);
        do_aw(32'h4000_0010, 4'd0, BURST_INCR, SIZE_WORD);
        do_w(32'hAABB_CCDD, 4'b0101, 1'b1);
        get_b(r);
        chk_cnt++; if (r !== RESP_OKAY) $display("FAIL strb_bresp: got %b required 00", r); else pass_cnt++;
        do_ar(32'h4000_0010, 4'd0, BURST_INCR, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if (d !== 32'h00BB_00DD) $display("FAIL strb_data: got %h required 00bb00dd", d); else pass_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] r; logic l;
        do_ar(32'h4000_1000, 4'd0, BURST_INCR, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if ({d, r, l} !== {32'd0, RESP_SLVERR, 1'b1})
            $display("FAIL oor_read: got d=%h r=%b l=%b required 0/10/1", d, r, l); else pass_cnt++;
        chk_cnt++; if ({rvalid, arready} !== 2'b01) $display("FAIL oor_onebeat: rvalid/arready=%b required 01", {rvalid, arready}); else pass_cnt++;
        do_aw(32'h4000_1000, 4'd0, BURST_INCR, SIZE_WORD);
        do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        get_b(r);
        chk_cnt++; if (r !== RESP_SLVERR) $display("FAIL oor_bresp: got %b required 10", r); else pass_cnt++;
        do_ar(32'h4000_0000, 4'd0, BURST_INCR, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if (d !== 32'h11) $display("FAIL oor_nowrite: got %h required 11", d); else pass_cnt++;
        write_burst(32'h4000_0FFC, 4'd0, 32'h0FFC_0FFC, 32'd0, r);
        chk_cnt++; if (r !== RESP_OKAY) $display("FAIL top_bresp: got %b required 00", r); else pass_cnt++;
        do_ar(32'h4000_0FFC, 4'd0, BURST_INCR, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if ({d, r} !== {32'h0FFC_0FFC, RESP_OKAY}) $display("FAIL top_read: got %h/%b required 0ffc0ffc/00", d, r); else pass_cnt++;
        do_ar(32'h3FFF_FFFC, 4'd0, BURST_INCR, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if ({d, r} !== {32'd0, RESP_SLVERR}) $display("FAIL below_read: got %h/%b required 0/10", d, r); else pass_cnt++;
        do_ar(32'h4000_0000, 4'd0, BURST_WRAP, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if ({d, r} !== {32'd0, RESP_SLVERR}) $display("FAIL wrap_read: got %h/%b required 0/10", d, r); else pass_cnt++;
        do_ar(32'h4000_0000, 4'd0, BURST_INCR, 3'b001);
        get_r(d, r, l);
        chk_cnt++; if ({d, r} !== {32'd0, RESP_SLVERR}) $display("FAIL size_read: got %h/%b required 0/10", d, r); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [1:0] r; logic l;
        do_ar(32'h4000_0000, 4'd1, BURST_INCR, SIZE_WORD);
        rready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 6; k++) begin
                if (k == 5) rready = 1'b1;
                chk_cnt++;
                if ({rvalid, rdata, rresp, rlast} !== {1'b1, 32'h11 * 32'(b + 1), RESP_OKAY, b == 1})
                    $display("FAIL hold_b%0d_c%0d: got v=%b d=%h l=%b required d=%h l=%b",
                             b, k, rvalid, rdata, rlast, 32'h11 * 32'(b + 1), b == 1);
                else pass_cnt++;
                tick();
            end
            rready = 1'b0;
        end
        chk_cnt++; if (rvalid !== 1'b0) $display("FAIL hold_done: rvalid=%b required 0", rvalid); else pass_cnt++;
        write_burst(32'h4000_0020, 4'd1, 32'h5555, 32'h1111, r);
        do_aw(32'h4000_0020, 4'd1, BURST_INCR, SIZE_WORD);
        do_w(32'h7777, 4'hF, 1'b1);
        do_w(32'h8888, 4'hF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk_cnt++;
            if ({bvalid, bresp} !== {1'b1, RESP_SLVERR}) $display("FAIL bhold_c%0d: got %b required 110", k, {bvalid, bresp}); else pass_cnt++;
            tick();
        end
        get_b(r);
        chk_cnt++; if (r !== RESP_SLVERR) $display("FAIL wlast_bresp: got %b required 10", r); else pass_cnt++;
        do_ar(32'h4000_0020, 4'd1, BURST_INCR, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if (d !== 32'h5555) $display("FAIL wlast_keep0: got %h required 5555", d); else pass_cnt++;
        get_r(d, r, l);
        chk_cnt++; if (d !== 32'h6666) $display("FAIL wlast_keep1: got %h required 6666", d); else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        logic [31:0] d; logic [1:0] r; logic l;
        write_burst(32'h4000_0030, 4'd0, 32'hCAFE_0001, 32'd0, r);
        awaddr = 32'h4000_0030; awlen = 4'd0; awburst = BURST_INCR; awsize = SIZE_WORD; awvalid = 1'b1;
        araddr = 32'h4000_0030; arlen = 4'd0; arburst = BURST_INCR; arsize = SIZE_WORD; arvalid = 1'b1;
        chk_cnt++; if ({awready, arready} !== 2'b11) $display("FAIL sc_ready: got %b required 11", {awready, arready}); else pass_cnt++;
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        do_w(32'hBEEF_0002, 4'hF, 1'b1);
        chk_cnt++; if ({rvalid, rdata} !== {1'b1, 32'hCAFE_0001}) $display("FAIL sc_old: got %b/%h required 1/cafe0001", rvalid, rdata); else pass_cnt++;
        get_r(d, r, l);
        get_b(r);
        do_ar(32'h4000_0030, 4'd0, BURST_INCR, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if (d !== 32'hBEEF_0002) $display("FAIL sc_new: got %h required beef0002", d); else pass_cnt++;
        do_aw(32'h4000_0030, 4'd0, BURST_INCR, SIZE_WORD);
        wdata = 32'hBEEF_0003; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        araddr = 32'h4000_0030; arlen = 4'd0; arburst = BURST_INCR; arsize = SIZE_WORD; arvalid = 1'b1;
        tick();
        wvalid = 1'b0; arvalid = 1'b0;
        chk_cnt++; if ({rvalid, rdata} !== {1'b1, 32'hBEEF_0002}) $display("FAIL sc_prewrite: got %b/%h required 1/beef0002", rvalid, rdata); else pass_cnt++;
        get_r(d, r, l);
        get_b(r);
        do_ar(32'h4000_0030, 4'd0, BURST_INCR, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if (d !== 32'hBEEF_0003) $display("FAIL sc_after: got %h required beef0003", d); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d; logic [1:0] r; logic l;
        do_ar(32'h4000_0000, 4'd7, BURST_INCR, SIZE_WORD);
        rready = 1'b1;
        tick();
        chk_cnt++; if (rdata !== 32'h22) $display("FAIL mid_beat2: got %h required 22", rdata); else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; rready = 1'b0;
        chk_cnt++; if ({rvalid, arready, bvalid} !== 3'b010) $display("FAIL mid_reset: v/ar/b=%b required 010", {rvalid, arready, bvalid}); else pass_cnt++;
        do_ar(32'h4000_0004, 4'd1, BURST_INCR, SIZE_WORD);
        get_r(d, r, l);
        chk_cnt++; if ({d, r, l} !== {32'h22, RESP_OKAY, 1'b0}) $display("FAIL mid_new0: got %h/%b/%b required 22/00/0", d, r, l); else pass_cnt++;
        get_r(d, r, l);
        chk_cnt++; if ({d, r, l} !== {32'h33, RESP_OKAY, 1'b1}) $display("FAIL mid_new1: got %h/%b/%b required 33/00/1", d, r, l); else pass_cnt++;
    endtask

    task automatic test_long_and_fixed();
        logic [31:0] d; logic [1:0] r; logic l;
        write_burst(32'h4000_0100, 4'd15, 32'h1000, 32'd1, r);
        chk_cnt++; if (r !== RESP_OKAY) $display("FAIL len15_bresp: got %b required 00", r); else pass_cnt++;
        do_ar(32'h4000_0100, 4'd15, BURST_INCR, SIZE_WORD);
        rready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_cnt++;
            if ({rvalid, rdata, rlast} !== {1'b1, 32'h1000 + 32'(i), i == 15})
                $display("FAIL len15_beat%0d: got v=%b d=%h l=%b required d=%h l=%b", i, rvalid, rdata, rlast, 32'h1000 + 32'(i), i == 15);
            else pass_cnt++;
            tick();
        end
        rready = 1'b0;
        chk_cnt++; if (rvalid !== 1'b0) $display("FAIL len15_done: rvalid=%b required 0", rvalid); else pass_cnt++;
        do_aw(32'h4000_0200, 4'd1, BURST_FIXED, SIZE_WORD);
        do_w(32'hAAAA_0001, 4'hF, 1'b0);
        do_w(32'hBBBB_0002, 4'hF, 1'b1);
        get_b(r);
        chk_cnt++; if (r !== RESP_OKAY) $display("FAIL fixed_bresp: got %b required 00", r); else pass_cnt++;
        do_ar(32'h4000_0200, 4'd1, BURST_FIXED, SIZE_WORD);
        for (int i = 0; i < 2; i++) begin
            get_r(d, r, l);
            chk_cnt++;
            if ({d, r, l} !== {32'hBBBB_0002, RESP_OKAY, i == 1})
                $display("FAIL fixed_beat%0d: got %h/%b/%b required bbbb0002/00/%b", i, d, r, l, i == 1);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        arvalid = 1'b0; araddr = '0; arburst = '0; arlen = '0; arsize = '0;
        awvalid = 1'b0; awaddr = '0; awburst = '0; awlen = '0; awsize = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        rready = 1'b0; bready = 1'b0;
        test_reset();
        test_incr();
        test_strobe();
        test_errors();
        test_backpressure();
        test_same_cycle();
        test_reset_mid_burst();
        test_long_and_fixed();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
